// File: rtl/move_select_if.sv
// Bundle between the board/turn source, move_select and the game-state update block.
// Groups the button inputs, the committed game state and the evaluated candidate move.
interface move_select_if;
   logic        btn_next;
   logic        btn_prev;
   logic [17:0] curr_move;
   logic [2:0]  curr_state;
   logic [1:0]  curr_turn;
   logic [3:0]  cursor;
   logic        valid_move;
   logic [17:0] next_move;
   logic [2:0]  next_state;
   logic [1:0]  next_turn;
   logic [3:0]  count;
   logic [2:0]  temp_state;

   // There is no backpressure: valid_move qualifies the candidate bundle on every
   // cycle, and the update block samples the whole bundle on its own OK edge.
   modport master (
      output btn_next, btn_prev, curr_move, curr_state, curr_turn,
      input  cursor, valid_move, next_move, next_state, next_turn, count, temp_state
   );

   modport slave (
      input  btn_next, btn_prev, curr_move, curr_state, curr_turn,
      output cursor, valid_move, next_move, next_state, next_turn, count, temp_state
   );
endinterface

// File: rtl/move_select.sv
// Cursor, turn countdown and candidate-move evaluation feeding the game-state update block.
// Optional MOVE_SELECT_SKIP_OCCUPIED_EN: cursor buttons skip occupied cells.
module move_select #(
   parameter int CLK_PER_TICK = 50000000,
   parameter int TURN_TIME    = 9
) (
   input logic          clk,
   input logic          reset_n,
   move_select_if.slave bus
);
   localparam logic [2:0] ST_INIT = 3'd0;
   localparam logic [2:0] ST_PLAY = 3'd1;
   localparam logic [2:0] ST_AWIN = 3'd2;
   localparam logic [2:0] ST_BWIN = 3'd3;
   localparam logic [2:0] ST_DRAW = 3'd4;
   localparam logic [1:0] TURN_A  = 2'b01;
   localparam logic [1:0] TURN_B  = 2'b10;
   localparam logic [3:0] COUNT_RELOAD = 4'(TURN_TIME);
   localparam int         PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_TICK - 1);

   logic [1:0]    next_sync, prev_sync;
   logic          next_seen, prev_seen;
   logic          next_pulse, prev_pulse;
   logic [1:0]    turn_q;
   logic          turn_change, in_play;
   logic [8:0]    occ, cell_mask, mover_cells;
   logic [3:0]    cursor_q, cursor_nxt;
   logic [PW-1:0] presc_q;
   logic [3:0]    count_q;
   logic          turn_ok, legal;
   logic [17:0]   cand_move;
   logic [2:0]    cand_state;
   logic          valid_q;
   logic [17:0]   move_q;
   logic [2:0]    state_q, temp_q;
   logic [1:0]    nturn_q;

   function automatic logic has_line(input logic [8:0] c);
      has_line = (c[0] & c[1] & c[2]) | (c[3] & c[4] & c[5]) | (c[6] & c[7] & c[8]) |
                 (c[0] & c[3] & c[6]) | (c[1] & c[4] & c[7]) | (c[2] & c[5] & c[8]) |
                 (c[0] & c[4] & c[8]) | (c[2] & c[4] & c[6]);
   endfunction

`ifdef MOVE_SELECT_SKIP_OCCUPIED_EN
   // Walk up to 8 cells in the chosen direction; stay put when every other cell is taken.
   function automatic logic [3:0] seek_free(input logic [3:0] from, input logic [8:0] taken,
                                            input logic fwd);
      logic [3:0] pos;
      logic       found;
      pos       = from;
      found     = 1'b0;
      seek_free = from;
      for (int k = 0; k < 8; k++) begin
         if (fwd) pos = (pos == 4'd8) ? 4'd0 : pos + 4'd1;
         else     pos = (pos == 4'd0) ? 4'd8 : pos - 4'd1;
         if (!found && !taken[pos]) begin
            seek_free = pos;
            found     = 1'b1;
         end
      end
   endfunction

   function automatic logic [3:0] lowest_free(input logic [8:0] taken);
      lowest_free = 4'd0;
      for (int i = 8; i >= 0; i--)
         if (!taken[i]) lowest_free = 4'(i);
   endfunction
`endif

   assign next_pulse  = next_sync[1] & ~next_seen;
   assign prev_pulse  = prev_sync[1] & ~prev_seen;
   assign turn_change = (bus.curr_turn != turn_q);
   assign in_play     = (bus.curr_state == ST_PLAY);
   assign occ         = bus.curr_move[8:0] | bus.curr_move[17:9];
   assign cell_mask   = 9'b1 << cursor_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         next_sync <= 2'b00;
         prev_sync <= 2'b00;
         next_seen <= 1'b0;
         prev_seen <= 1'b0;
      end else begin
         next_sync <= {next_sync[0], bus.btn_next};
         prev_sync <= {prev_sync[0], bus.btn_prev};
         next_seen <= next_sync[1];
         prev_seen <= prev_sync[1];
      end
   end

   // A turn change outranks any button pulse landing in the same cycle.
   always_comb begin
      cursor_nxt = cursor_q;
      if (!in_play) cursor_nxt = 4'd0;
`ifdef MOVE_SELECT_SKIP_OCCUPIED_EN
      else if (turn_change) cursor_nxt = lowest_free(occ);
      else if (next_pulse && !prev_pulse) cursor_nxt = seek_free(cursor_q, occ, 1'b1);
      else if (prev_pulse && !next_pulse) cursor_nxt = seek_free(cursor_q, occ, 1'b0);
`else
      else if (turn_change) cursor_nxt = 4'd0;
      else if (next_pulse && !prev_pulse) cursor_nxt = (cursor_q == 4'd8) ? 4'd0 : cursor_q + 4'd1;
      else if (prev_pulse && !next_pulse) cursor_nxt = (cursor_q == 4'd0) ? 4'd8 : cursor_q - 4'd1;
`endif
   end

   always_comb begin
      cand_move   = bus.curr_move;
      mover_cells = 9'd0;
      turn_ok     = 1'b0;
      case (bus.curr_turn)
         TURN_A: begin
            cand_move[8:0] = bus.curr_move[8:0] | cell_mask;
            mover_cells    = bus.curr_move[8:0] | cell_mask;
            turn_ok        = 1'b1;
         end
         TURN_B: begin
            cand_move[17:9] = bus.curr_move[17:9] | cell_mask;
            mover_cells     = bus.curr_move[17:9] | cell_mask;
            turn_ok         = 1'b1;
         end
         default: ;
      endcase
      legal      = in_play && ((occ & cell_mask) == 9'd0) && (count_q != 4'd0) && turn_ok;
      cand_state = bus.curr_state;
      // A completed line wins even when the same move fills the board.
      if (legal) begin
         if (has_line(mover_cells))
            cand_state = (bus.curr_turn == TURN_A) ? ST_AWIN : ST_BWIN;
         else if (&(cand_move[8:0] | cand_move[17:9]))
            cand_state = ST_DRAW;
         else
            cand_state = ST_PLAY;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cursor_q <= 4'd0;
         turn_q   <= TURN_A;
         valid_q  <= 1'b0;
         move_q   <= 18'd0;
         state_q  <= ST_INIT;
         nturn_q  <= TURN_A;
         temp_q   <= ST_INIT;
      end else begin
         cursor_q <= cursor_nxt;
         turn_q   <= bus.curr_turn;
         valid_q  <= legal;
         move_q   <= cand_move;
         state_q  <= cand_state;
         nturn_q  <= bus.curr_turn;
         temp_q   <= bus.curr_state;
      end
   end

   // Countdown holds at zero; the update block is the one that acts on the timeout.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         count_q <= COUNT_RELOAD;
      end else if (!in_play || turn_change) begin
         presc_q <= '0;
         count_q <= COUNT_RELOAD;
      end else if (presc_q == PRESC_LAST) begin
         presc_q <= '0;
         if (count_q != 4'd0) count_q <= count_q - 4'd1;
      end else begin
         presc_q <= presc_q + 1'b1;
      end
   end

   assign bus.cursor     = cursor_q;
   assign bus.valid_move = valid_q;
   assign bus.next_move  = move_q;
   assign bus.next_state = state_q;
   assign bus.next_turn  = nturn_q;
   assign bus.count      = count_q;
   assign bus.temp_state = temp_q;
endmodule

// File: tb/tb_move_select.sv
// Bench for move_select: a cycle model built from the game rules is compared every cycle,
// with directed scenarios pinning hand-computed results.
module tb_move_select;
  localparam int CPT = 4;
  localparam int TT  = 9;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  move_select_if bus();

  move_select #(.CLK_PER_TICK(CPT), .TURN_TIME(TT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  int          m_cursor, m_elapsed;
  logic [1:0]  m_prev_turn;
  logic [2:0]  m_bn, m_bp;
  logic [8:0]  m_occ;
  logic [17:0] m_nm;
  logic        m_legal, m_pn, m_pp;
  logic        e_valid;
  logic [17:0] e_move;
  logic [2:0]  e_state, e_temp;
  logic [1:0]  e_turn;

  function automatic int exp_count(input int elapsed);
    if (elapsed / CPT >= TT) return 0;
    return TT - elapsed / CPT;
  endfunction

  function automatic bit wins(input logic [8:0] c);
    for (int l = 0; l < 8; l++)
      if (c[lines[l][0]] && c[lines[l][1]] && c[lines[l][2]]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_step(input int cur, input logic [8:0] occ, input bit fwd);
`ifdef MOVE_SELECT_SKIP_OCCUPIED_EN
    int p;
    for (int k = 1; k <= 8; k++) begin
      p = fwd ? (cur + k) % 9 : (cur - k + 9) % 9;
      if (!occ[p]) return p;
    end
    return cur;
`else
    if (occ == 9'h1FF) return fwd ? (cur + 1) % 9 : (cur + 8) % 9;
    return fwd ? (cur + 1) % 9 : (cur + 8) % 9;
`endif
  endfunction

  function automatic int m_turn_home(input logic [8:0] occ);
`ifdef MOVE_SELECT_SKIP_OCCUPIED_EN
    for (int i = 0; i < 9; i++) if (!occ[i]) return i;
    return 0;
`else
    if (occ == 9'h1FF) return 0;
    return 0;
`endif
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cursor = 0; m_elapsed = 0; m_prev_turn = 2'b01;
      m_bn = 3'b000; m_bp = 3'b000;
      e_valid = 1'b0; e_move = 18'd0; e_state = 3'd0; e_turn = 2'b01; e_temp = 3'd0;
    end else begin
      m_occ = bus.curr_move[8:0] | bus.curr_move[17:9];
      m_nm  = bus.curr_move;
      if (bus.curr_turn == 2'b01) m_nm[m_cursor] = 1'b1;
      else if (bus.curr_turn == 2'b10) m_nm[9 + m_cursor] = 1'b1;
      m_legal = (bus.curr_state == 3'd1) && !m_occ[m_cursor] && (exp_count(m_elapsed) != 0) &&
                (bus.curr_turn == 2'b01 || bus.curr_turn == 2'b10);
      e_move = m_nm; e_turn = bus.curr_turn; e_temp = bus.curr_state; e_valid = m_legal;
      if (!m_legal) e_state = bus.curr_state;
      else if (wins(bus.curr_turn == 2'b01 ? m_nm[8:0] : m_nm[17:9]))
        e_state = (bus.curr_turn == 2'b01) ? 3'd2 : 3'd3;
      else if ((m_nm[8:0] | m_nm[17:9]) == 9'h1FF) e_state = 3'd4;
      else e_state = 3'd1;
      // A press seen two samples ago, not three, reaches the cursor now.
      m_pn = m_bn[1] & ~m_bn[2];
      m_pp = m_bp[1] & ~m_bp[2];
      if (bus.curr_state != 3'd1) m_cursor = 0;
      else if (bus.curr_turn != m_prev_turn) m_cursor = m_turn_home(m_occ);
      else if (m_pn && !m_pp) m_cursor = m_step(m_cursor, m_occ, 1'b1);
      else if (m_pp && !m_pn) m_cursor = m_step(m_cursor, m_occ, 1'b0);
      if (bus.curr_state != 3'd1 || bus.curr_turn != m_prev_turn) m_elapsed = 0;
      else if (m_elapsed < 100000) m_elapsed++;
      m_prev_turn = bus.curr_turn;
      m_bn = {m_bn[1:0], bus.btn_next};
      m_bp = {m_bp[1:0], bus.btn_prev};
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      check("cursor",     32'(bus.cursor),     32'(m_cursor));
      check("valid_move", 32'(bus.valid_move), 32'(e_valid));
      check("next_move",  32'(bus.next_move),  32'(e_move));
      check("next_state", 32'(bus.next_state), 32'(e_state));
      check("next_turn",  32'(bus.next_turn),  32'(e_turn));
      check("count",      32'(bus.count),      32'(exp_count(m_elapsed)));
      check("temp_state", 32'(bus.temp_state), 32'(e_temp));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic restart(input logic [1:0] turn);
    @(negedge clk);
    bus.curr_state = 3'd0; bus.curr_turn = turn; bus.curr_move = 18'd0;
    @(negedge clk);
    bus.curr_state = 3'd1;
  endtask

  task automatic press(input logic nx, input logic pv);
    bus.btn_next = nx; bus.btn_prev = pv;
    repeat (2) @(negedge clk);
    bus.btn_next = 1'b0; bus.btn_prev = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic goto_cell(input int n, input logic [1:0] turn);
    restart(turn);
    for (int i = 0; i < n; i++) press(1'b1, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " cursor"},     32'(bus.cursor),     32'd0);
    check({tag, " valid_move"}, 32'(bus.valid_move), 32'd0);
    check({tag, " next_move"},  32'(bus.next_move),  32'd0);
    check({tag, " next_state"}, 32'(bus.next_state), 32'd0);
    check({tag, " next_turn"},  32'(bus.next_turn),  32'd1);
    check({tag, " count"},      32'(bus.count),      32'd9);
    check({tag, " temp_state"}, 32'(bus.temp_state), 32'd0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int budget;
    bus.btn_next = 1'b0; bus.btn_prev = 1'b0;
    bus.curr_move = 18'd0; bus.curr_state = 3'd0; bus.curr_turn = 2'b01;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    #2 reset_n = 1'b1;

    // Three next presses on an empty board.
    goto_cell(3, 2'b01);
    repeat (2) @(negedge clk);
    check("three_next cursor", 32'(bus.cursor), 32'd3);
    check("three_next next_move", 32'(bus.next_move), 32'h00008);
    check("three_next valid", 32'(bus.valid_move), 32'd1);
    check("three_next state", 32'(bus.next_state), 32'd1);
    check("three_next turn", 32'(bus.next_turn), 32'd1);

    // A completes the top row.
    goto_cell(2, 2'b01);
    bus.curr_move = 18'h02003;
    repeat (2) @(negedge clk);
    check("awin state", 32'(bus.next_state), 32'd2);
    check("awin valid", 32'(bus.valid_move), 32'd1);
    check("awin next_move", 32'(bus.next_move), 32'h02007);

    // Occupied target cell.
    goto_cell(4, 2'b01);
    bus.curr_move = 18'h02003;
    repeat (2) @(negedge clk);
    check("occupied valid", 32'(bus.valid_move), 32'd0);
    check("occupied state", 32'(bus.next_state), 32'd1);

    // Ninth move with no line: draw.
    goto_cell(6, 2'b10);
    bus.curr_move = 18'h0658D;
    repeat (2) @(negedge clk);
    check("draw state", 32'(bus.next_state), 32'd4);
    check("draw next_move", 32'(bus.next_move), 32'h0E58D);

    // Ninth move completing B's 2-4-6 diagonal: win outranks draw.
    goto_cell(6, 2'b10);
    bus.curr_move = 18'h039A3;
    repeat (2) @(negedge clk);
    check("bwin state", 32'(bus.next_state), 32'd3);
    check("bwin valid", 32'(bus.valid_move), 32'd1);

    // First tick lands exactly CPT clocks after entering PLAY.
    restart(2'b01);
    repeat (3) @(negedge clk);
    check("count before tick", 32'(bus.count), 32'd9);
    @(negedge clk);
    check("count first tick", 32'(bus.count), 32'd8);

    // Countdown to zero, saturate, then a turn change reloads.
    goto_cell(5, 2'b01);
    budget = 0;
    while (bus.count != 4'd0 && budget < 80) begin
      @(negedge clk);
      budget++;
    end
    check("countdown reached zero in budget", 32'(budget < 80), 32'd1);
    repeat (2) @(negedge clk);
    check("timeout valid", 32'(bus.valid_move), 32'd0);
    repeat (8) @(negedge clk);
    check("count saturates", 32'(bus.count), 32'd0);
    check("cursor before turn change", 32'(bus.cursor), 32'd5);
    bus.curr_turn = 2'b10;
    @(negedge clk);
    check("turn change count", 32'(bus.count), 32'd9);
    check("turn change cursor", 32'(bus.cursor), 32'd0);

    // Wrap backwards, simultaneous buttons, and presses outside PLAY.
    restart(2'b01);
    press(1'b0, 1'b1);
    check("prev wraps", 32'(bus.cursor), 32'd8);
    press(1'b1, 1'b1);
    check("both buttons", 32'(bus.cursor), 32'd8);
    @(negedge clk);
    bus.curr_state = 3'd0;
    press(1'b1, 1'b0);
    check("init press", 32'(bus.cursor), 32'd0);

    // Asynchronous reset between clock edges.
    goto_cell(2, 2'b01);
    repeat (5) @(negedge clk);
    check("pre-reset cursor", 32'(bus.cursor), 32'd2);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_values("async reset");
    @(negedge clk);
    bus.curr_state = 3'd0;
    #2 reset_n = 1'b1;

    // Next press with cells 1 and 2 taken.
    restart(2'b01);
    bus.curr_move = 18'h00006;
    press(1'b1, 1'b0);
`ifdef MOVE_SELECT_SKIP_OCCUPIED_EN
    check("skip occupied", 32'(bus.cursor), 32'd3);
`else
    check("single step", 32'(bus.cursor), 32'd1);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
